// File: rtl/fp_exc_monitor.sv
// IEEE-754 exception classifier with sticky flags and saturating counters; optional irq via FP_EXC_MON_IRQ_EN.
// Latency: 1 cycle input to out_*. Backpressure: single output register, in_ready = !out_valid || out_ready.
// Flags and counters update on the accept edge, so a stalled output is never counted twice.
module fp_exc_monitor #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23,
    parameter int CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [EXP_W+MAN_W:0]   fp_input,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic                   out_sign,
    output logic [2:0]             out_class,
    output logic                   overflow,
    output logic                   underflow,
    output logic                   sticky_ovf,
    output logic                   sticky_unf,
    input  logic                   clear_sticky,
    output logic [CNT_W-1:0]       ovf_count,
    output logic [CNT_W-1:0]       unf_count,
    output logic                   irq
);

    localparam int W = EXP_W + MAN_W + 1;

    localparam logic [2:0] C_ZERO   = 3'd0;
    localparam logic [2:0] C_DENORM = 3'd1;
    localparam logic [2:0] C_NORMAL = 3'd2;
    localparam logic [2:0] C_INF    = 3'd3;
    localparam logic [2:0] C_QNAN   = 3'd4;
    localparam logic [2:0] C_SNAN   = 3'd5;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [EXP_W-1:0] exp_f;
    logic [MAN_W-1:0] man_f;
    logic [2:0]       in_class;
    logic             in_ovf;
    logic             in_unf;
    logic             accept;
    logic             ovf_evt;
    logic             unf_evt;

    assign exp_f    = fp_input[W-2:MAN_W];
    assign man_f    = fp_input[MAN_W-1:0];
    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready && !rst;

    always_comb begin
        in_class = C_NORMAL;
        if (exp_f == '0) begin
            in_class = (man_f == '0) ? C_ZERO : C_DENORM;
        end else if (&exp_f) begin
            if (man_f == '0)
                in_class = C_INF;
            else if (man_f[MAN_W-1])
                in_class = C_QNAN;
            else
                in_class = C_SNAN;
        end
    end

    assign in_ovf  = (in_class == C_INF) || (in_class == C_QNAN) || (in_class == C_SNAN);
    assign in_unf  = (in_class == C_ZERO) || (in_class == C_DENORM);
    assign ovf_evt = accept && in_ovf;
    assign unf_evt = accept && in_unf;

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_sign  <= 1'b0;
            out_class <= C_ZERO;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else if (accept) begin
            out_valid <= 1'b1;
            out_sign  <= fp_input[W-1];
            out_class <= in_class;
            overflow  <= in_ovf;
            underflow <= in_unf;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    // A clear colliding with an event restarts that event's flag and count at 1.
    always_ff @(posedge clk) begin
        if (rst) begin
            sticky_ovf <= 1'b0;
            sticky_unf <= 1'b0;
            ovf_count  <= '0;
            unf_count  <= '0;
        end else if (clear_sticky) begin
            sticky_ovf <= ovf_evt;
            sticky_unf <= unf_evt;
            ovf_count  <= ovf_evt ? CNT_ONE : '0;
            unf_count  <= unf_evt ? CNT_ONE : '0;
        end else begin
            if (ovf_evt) begin
                sticky_ovf <= 1'b1;
                if (ovf_count != CNT_MAX)
                    ovf_count <= ovf_count + CNT_ONE;
            end
            if (unf_evt) begin
                sticky_unf <= 1'b1;
                if (unf_count != CNT_MAX)
                    unf_count <= unf_count + CNT_ONE;
            end
        end
    end

`ifdef FP_EXC_MON_IRQ_EN
    logic sticky_ovf_d;
    logic sticky_unf_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            irq          <= 1'b0;
            sticky_ovf_d <= 1'b0;
            sticky_unf_d <= 1'b0;
        end else begin
            irq          <= (sticky_ovf && !sticky_ovf_d) || (sticky_unf && !sticky_unf_d);
            sticky_ovf_d <= sticky_ovf;
            sticky_unf_d <= sticky_unf;
        end
    end
`else
    assign irq = 1'b0;
`endif

endmodule

// File: tb/tb_fp_exc_monitor.sv
// Randomized plus directed bench for fp_exc_monitor with a queue-based scoreboard.
module tb_fp_exc_monitor;
    localparam int EXP_W   = 8;
    localparam int MAN_W   = 23;
    localparam int W       = EXP_W + MAN_W + 1;
    localparam int CNT_W   = 16;
    localparam int CNT_W_S = 2;
    localparam longint MAX_L = (longint'(1) << CNT_W) - 1;
    localparam longint MAX_S = (longint'(1) << CNT_W_S) - 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst, in_valid, out_ready, clear_sticky;
    logic [W-1:0] fp_input;

    logic             in_ready, out_valid, out_sign, overflow, underflow, sticky_ovf, sticky_unf, irq;
    logic [2:0]       out_class;
    logic [CNT_W-1:0] ovf_count, unf_count;

    logic               in_ready_s, out_valid_s, out_sign_s, overflow_s, underflow_s;
    logic               sticky_ovf_s, sticky_unf_s, irq_s;
    logic [2:0]         out_class_s;
    logic [CNT_W_S-1:0] ovf_count_s, unf_count_s;

    fp_exc_monitor #(.EXP_W(EXP_W), .MAN_W(MAN_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .fp_input(fp_input),
        .out_valid(out_valid), .out_ready(out_ready), .out_sign(out_sign), .out_class(out_class),
        .overflow(overflow), .underflow(underflow), .sticky_ovf(sticky_ovf), .sticky_unf(sticky_unf),
        .clear_sticky(clear_sticky), .ovf_count(ovf_count), .unf_count(unf_count), .irq(irq)
    );

    fp_exc_monitor #(.EXP_W(EXP_W), .MAN_W(MAN_W), .CNT_W(CNT_W_S)) dut_s (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_s), .fp_input(fp_input),
        .out_valid(out_valid_s), .out_ready(out_ready), .out_sign(out_sign_s), .out_class(out_class_s),
        .overflow(overflow_s), .underflow(underflow_s), .sticky_ovf(sticky_ovf_s), .sticky_unf(sticky_unf_s),
        .clear_sticky(clear_sticky), .ovf_count(ovf_count_s), .unf_count(unf_count_s), .irq(irq_s)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    typedef struct {
        int cls;
        int sign;
        int ovf;
        int unf;
    } exp_t;

    exp_t   q[$];
    longint m_ovf_cnt, m_unf_cnt, m_ovf_cnt_s, m_unf_cnt_s;
    int     m_sticky_ovf, m_sticky_unf, m_irq, m_rose_last;

    // Class straight from the IEEE-754 field definitions.
    function automatic int classify(input logic [W-1:0] w);
        longint v, e, m, emax;
        v    = longint'(w);
        emax = (longint'(1) << EXP_W) - 1;
        e    = (v / (longint'(1) << MAN_W)) % (emax + 1);
        m    = v % (longint'(1) << MAN_W);
        if (e == 0)    return (m == 0) ? 0 : 1;
        if (e == emax) begin
            if (m == 0) return 3;
            return (m >= (longint'(1) << (MAN_W - 1))) ? 4 : 5;
        end
        return 2;
    endfunction

    function automatic longint sat_inc(input longint c, input longint mx);
        return (c >= mx) ? mx : c + 1;
    endfunction

    // Reference model, advanced on every clock edge.
    always @(posedge clk) begin
        int  cls, ov, un, old_so, old_su;
        bit  acc;
        if (rst) begin
            q.delete();
            m_ovf_cnt = 0; m_unf_cnt = 0; m_ovf_cnt_s = 0; m_unf_cnt_s = 0;
            m_sticky_ovf = 0; m_sticky_unf = 0; m_irq = 0; m_rose_last = 0;
        end else begin
            acc    = in_valid && ((q.size() == 0) || out_ready);
            cls    = classify(fp_input);
            ov     = (cls >= 3) ? 1 : 0;
            un     = (cls <= 1) ? 1 : 0;
            old_so = m_sticky_ovf;
            old_su = m_sticky_unf;
            if (clear_sticky) begin
                m_sticky_ovf = (acc && ov) ? 1 : 0;
                m_sticky_unf = (acc && un) ? 1 : 0;
                m_ovf_cnt    = m_sticky_ovf; m_ovf_cnt_s = m_sticky_ovf;
                m_unf_cnt    = m_sticky_unf; m_unf_cnt_s = m_sticky_unf;
            end else if (acc) begin
                if (ov) begin
                    m_sticky_ovf = 1;
                    m_ovf_cnt    = sat_inc(m_ovf_cnt, MAX_L);
                    m_ovf_cnt_s  = sat_inc(m_ovf_cnt_s, MAX_S);
                end
                if (un) begin
                    m_sticky_unf = 1;
                    m_unf_cnt    = sat_inc(m_unf_cnt, MAX_L);
                    m_unf_cnt_s  = sat_inc(m_unf_cnt_s, MAX_S);
                end
            end
            if (acc) q.push_back('{cls, int'(fp_input[W-1]), ov, un});
            m_irq       = m_rose_last;
            m_rose_last = ((m_sticky_ovf && !old_so) || (m_sticky_unf && !old_su)) ? 1 : 0;
        end
    end

    // Monitor: compares the presented word against the queue head, pops on transfer.
    always @(negedge clk) begin
        int exp_irq;
`ifdef FP_EXC_MON_IRQ_EN
        exp_irq = m_irq;
`else
        exp_irq = 0;
`endif
        chk("in_ready",   in_ready,   (q.size() == 0) || out_ready);
        chk("in_ready_s", in_ready_s, (q.size() == 0) || out_ready);
        chk("out_valid",  out_valid,  q.size() != 0);
        chk("out_valid_s", out_valid_s, q.size() != 0);
        if (q.size() != 0) begin
            chk("out_class",   out_class,   q[0].cls);
            chk("out_class_s", out_class_s, q[0].cls);
            chk("out_sign",    out_sign,    q[0].sign);
            chk("overflow",    overflow,    q[0].ovf);
            chk("underflow",   underflow,   q[0].unf);
            if (out_ready) void'(q.pop_front());
        end
        chk("sticky_ovf",  sticky_ovf,  m_sticky_ovf);
        chk("sticky_unf",  sticky_unf,  m_sticky_unf);
        chk("ovf_count",   ovf_count,   m_ovf_cnt);
        chk("unf_count",   unf_count,   m_unf_cnt);
        chk("sticky_ovf_s", sticky_ovf_s, m_sticky_ovf);
        chk("ovf_count_s", ovf_count_s, m_ovf_cnt_s);
        chk("unf_count_s", unf_count_s, m_unf_cnt_s);
        chk("irq",         irq,         exp_irq);
        chk("irq_s",       irq_s,       exp_irq);
    end

    task automatic cyc(input logic v, input logic [W-1:0] w, input logic r, input logic c, input logic rs);
        in_valid = v; fp_input = w; out_ready = r; clear_sticky = c; rst = rs;
        @(posedge clk); #1;
    endtask

    // Holds the word until the handshake completes, bounded.
    task automatic send(input logic [W-1:0] w);
        bit acc;
        int budget;
        in_valid = 1'b1; fp_input = w; clear_sticky = 1'b0; rst = 1'b0;
        budget = 0;
        do begin
            acc = in_ready;
            @(posedge clk); #1;
            budget++;
        end while (!acc && budget < 20);
        if (!acc) begin
            errors++;
            $display("FAIL send_timeout actual=%0d required=%0d", budget, 1);
        end
        in_valid = 1'b0;
    endtask

    task automatic reset_outputs_chk();
        @(negedge clk);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_class", out_class, 0);
        chk("rst_out_sign",  out_sign,  0);
        chk("rst_overflow",  overflow,  0);
        chk("rst_underflow", underflow, 0);
        chk("rst_ovf_count", ovf_count, 0);
        chk("rst_unf_count", unf_count, 0);
        chk("rst_irq",       irq,       0);
    endtask

    function automatic logic [W-1:0] rand_word();
        logic [EXP_W-1:0] e;
        logic [MAN_W-1:0] m;
        case ($urandom_range(0, 2))
            0:       e = '0;
            1:       e = '1;
            default: e = EXP_W'($urandom);
        endcase
        case ($urandom_range(0, 3))
            0:       m = '0;
            1:       m = {1'b1, (MAN_W-1)'($urandom)};
            2:       m = {1'b0, (MAN_W-1)'($urandom_range(1, 255))};
            default: m = MAN_W'($urandom);
        endcase
        return {1'($urandom), e, m};
    endfunction

    int unf_tab[5] = '{1, 2, 3, 3, 3};

    initial begin
        in_valid = 0; out_ready = 0; clear_sticky = 0; fp_input = '0; rst = 1;
        repeat (2) @(posedge clk);
        #1 rst = 0;
        reset_outputs_chk();
        @(posedge clk); #1;

        out_ready = 1;
        send(32'h3F800000); send(32'h80000000); send(32'h00000001);
        send(32'h7F800000); send(32'h7FC00000); send(32'h7F800001);
        cyc(0, '0, 1, 0, 0);
        @(negedge clk);
        chk("t2_ovf_count", ovf_count, 3);
        chk("t1_unf_count", unf_count, 2);

        cyc(1, 32'h7F800000, 0, 0, 0);
        cyc(1, 32'h00000000, 0, 0, 0);
        cyc(1, 32'h3F800000, 0, 0, 0);
        cyc(1, 32'h7FC00000, 0, 0, 0);
        out_ready = 1;
        send(32'h00000000); send(32'h3F800000); send(32'h7FC00000);
        cyc(0, '0, 1, 0, 0);

        cyc(0, '0, 1, 1, 0);
        for (int i = 0; i < 5; i++) begin
            send(32'h00000000);
            @(negedge clk);
            chk("sat_unf_count_s", unf_count_s, unf_tab[i]);
        end

        cyc(1, 32'hFF800000, 1, 1, 0);
        @(negedge clk);
        chk("clr_sticky_ovf", sticky_ovf, 1);
        chk("clr_ovf_count",  ovf_count,  1);
        chk("clr_sticky_unf", sticky_unf, 0);
        chk("clr_unf_count",  unf_count,  0);

        cyc(1, 32'h7F800000, 0, 0, 0);
        cyc(0, '0, 0, 0, 1);
        reset_outputs_chk();
        @(posedge clk); #1;
        out_ready = 1;
        send(32'h7F800000); cyc(0, '0, 1, 0, 0); cyc(0, '0, 1, 0, 0);
        send(32'h7F800000); cyc(0, '0, 1, 0, 0); cyc(0, '0, 1, 0, 0);

        for (int i = 0; i < 3000; i++) begin
            cyc($urandom_range(0, 3) != 0, rand_word(), $urandom_range(0, 3) != 0,
                $urandom_range(0, 31) == 0, $urandom_range(0, 499) == 0);
        end
        cyc(0, '0, 1, 0, 0);
        cyc(0, '0, 1, 0, 0);
        @(negedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog actual=%0d required=%0d", $time, 2000000);
        $fatal(1, "watchdog expired");
    end
endmodule
